// File: rtl/q_learning_pkg.sv
// ============================================================================
// Module      : q_learning_pkg
// Description : Types and constants shared across the Q-learning update path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package q_learning_pkg;

    localparam int DATA_WIDTH = 32;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } fp32_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } q_state_e;

    // Learning constants consumed by the updater (binary32: 0.9 and 0.1)
    localparam logic [31:0] GAMMA_FP32 = 32'h3F666666;
    localparam logic [31:0] ALPHA_FP32 = 32'h3DCCCCCD;

endpackage

`default_nettype wire

// File: rtl/fp_greater.sv
// ============================================================================
// Module      : fp_greater
// Description : Combinational a > b on binary32 values; +0 and -0 are equal.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_greater
    import q_learning_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic                  o_gt
);

    fp32_t       w_a;
    fp32_t       w_b;
    logic [30:0] w_a_mag;
    logic [30:0] w_b_mag;
    logic        w_both_zero;

    assign w_a         = fp32_t'(i_a);
    assign w_b         = fp32_t'(i_b);
    assign w_a_mag     = {w_a.exp, w_a.mant};
    assign w_b_mag     = {w_b.exp, w_b.mant};
    assign w_both_zero = (w_a_mag == 31'd0) && (w_b_mag == 31'd0);

    // Sign-magnitude order: for negatives the smaller magnitude is larger
    always_comb begin
        o_gt = 1'b0;
        if (w_both_zero) begin
            o_gt = 1'b0;
        end else if (w_a.sign != w_b.sign) begin
            o_gt = ~w_a.sign;
        end else if (w_a.sign) begin
            o_gt = (w_a_mag < w_b_mag);
        end else begin
            o_gt = (w_a_mag > w_b_mag);
        end
    end

endmodule

`default_nettype wire

// File: rtl/q_max_selector.sv
// ============================================================================
// Module      : q_max_selector
// Description : Scans all action Q-values of a state and returns the maximum.
//               Optional argmax output enabled by macro Q_MAX_ACTION_OUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module q_max_selector #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_ACTIONS  = 4,
    parameter int STATE_WIDTH  = 4,
    parameter int ACTION_WIDTH = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                i_valid,
    input  logic [STATE_WIDTH-1:0]              i_next_state,
    output logic                                o_rd_en,
    output logic [STATE_WIDTH+ACTION_WIDTH-1:0] o_rd_addr,
    input  logic [DATA_WIDTH-1:0]               i_rd_data,
    output logic [DATA_WIDTH-1:0]               o_max_q,
`ifdef Q_MAX_ACTION_OUT_EN
    output logic [ACTION_WIDTH-1:0]             o_max_action,
`endif
    output logic                                o_valid,
    output logic                                o_busy
);

    import q_learning_pkg::*;

    localparam logic [ACTION_WIDTH-1:0] c_LAST_ACTION = ACTION_WIDTH'(NUM_ACTIONS - 1);

    q_state_e                r_state;
    q_state_e                w_state_nxt;
    logic [STATE_WIDTH-1:0]  r_state_idx;
    logic [ACTION_WIDTH-1:0] r_act_cnt;
    logic                    r_rd_pend;
    logic [ACTION_WIDTH-1:0] r_rd_act;
    logic [DATA_WIDTH-1:0]   r_max_q;
    logic                    w_last_rd;
    logic                    w_accept;
    logic                    w_gt;
    logic                    w_take;

    assign w_last_rd = (r_act_cnt == c_LAST_ACTION);
    assign w_accept  = (r_state == S_IDLE) && i_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_valid)   w_state_nxt = S_READ;
            S_READ:  if (w_last_rd) w_state_nxt = S_DRAIN;
            S_DRAIN: w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Read address generation; the state index is frozen for the whole scan
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_idx <= '0;
            r_act_cnt   <= '0;
            r_rd_pend   <= 1'b0;
            r_rd_act    <= '0;
        end else begin
            if (w_accept) begin
                r_state_idx <= i_next_state;
                r_act_cnt   <= '0;
            end else if ((r_state == S_READ) && !w_last_rd) begin
                r_act_cnt <= r_act_cnt + 1'b1;
            end
            r_rd_pend <= (r_state == S_READ);
            r_rd_act  <= r_act_cnt;
        end
    end

    fp_greater u_cmp (
        .i_a  (i_rd_data),
        .i_b  (r_max_q),
        .o_gt (w_gt)
    );

    // Action 0 seeds the running max; strict compare keeps the lowest index on ties
    assign w_take = r_rd_pend && ((r_rd_act == '0) || w_gt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_max_q <= '0;
        end else if (w_take) begin
            r_max_q <= i_rd_data;
        end
    end

`ifdef Q_MAX_ACTION_OUT_EN
    logic [ACTION_WIDTH-1:0] r_max_act;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_max_act <= '0;
        end else if (w_take) begin
            r_max_act <= r_rd_act;
        end
    end

    assign o_max_action = r_max_act;
`endif

    assign o_rd_en   = (r_state == S_READ);
    assign o_rd_addr = {r_state_idx, r_act_cnt};
    assign o_max_q   = r_max_q;
    assign o_valid   = (r_state == S_DONE);
    assign o_busy    = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_q_max_selector.sv
// ============================================================================
// Module      : tb_q_max_selector
// Description : Self-checking bench for q_max_selector with a Q-table model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_q_max_selector;

    typedef struct packed {
        logic [31:0] q;
        logic [1:0]  a;
    } exp_t;

    typedef struct packed {
        logic [3:0]       st;
        logic [3:0][31:0] row;
        logic [31:0]      q;
        logic [1:0]       a;
    } vec_t;

    logic        clk          = 1'b0;
    logic        rst_n        = 1'b0;
    logic        i_valid      = 1'b0;
    logic [3:0]  i_next_state = 4'd0;
    logic        o_rd_en;
    logic [5:0]  o_rd_addr;
    logic [31:0] i_rd_data    = 32'd0;
    logic [31:0] o_max_q;
`ifdef Q_MAX_ACTION_OUT_EN
    logic [1:0]  o_max_action;
`endif
    logic        o_valid;
    logic        o_busy;

    logic [31:0] tb_mem [64];
    exp_t        exp_q  [$];
    logic [5:0]  addr_q [$];
    int          cyc     = 0;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    q_max_selector #(
        .DATA_WIDTH   (32),
        .NUM_ACTIONS  (4),
        .STATE_WIDTH  (4),
        .ACTION_WIDTH (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_valid      (i_valid),
        .i_next_state (i_next_state),
        .o_rd_en      (o_rd_en),
        .o_rd_addr    (o_rd_addr),
        .i_rd_data    (i_rd_data),
        .o_max_q      (o_max_q),
`ifdef Q_MAX_ACTION_OUT_EN
        .o_max_action (o_max_action),
`endif
        .o_valid      (o_valid),
        .o_busy       (o_busy)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Q-table model: one-cycle read latency
    always @(posedge clk) begin
        if (o_rd_en) i_rd_data <= tb_mem[o_rd_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic fail_now(input string msg);
        n_tests++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", msg, cyc);
    endtask

    // Scoreboard monitor: read addresses and results checked against queues
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_rd_en) begin
                if (addr_q.size() == 0) fail_now($sformatf("rd_unexpected addr=%h", o_rd_addr));
                else chk("rd_addr", {26'd0, o_rd_addr}, {26'd0, addr_q.pop_front()});
            end
            if (o_valid) begin
                if (exp_q.size() == 0) begin
                    fail_now($sformatf("valid_unexpected max_q=%h", o_max_q));
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("max_q", o_max_q, e.q);
`ifdef Q_MAX_ACTION_OUT_EN
                    chk("max_action", {30'd0, o_max_action}, {30'd0, e.a});
`endif
                end
            end
        end
    end

    function automatic vec_t mk(input logic [3:0] st, input logic [31:0] d0, input logic [31:0] d1,
                                input logic [31:0] d2, input logic [31:0] d3,
                                input logic [31:0] q, input logic [1:0] a);
        vec_t v;
        v.st  = st;
        v.row = {d3, d2, d1, d0};
        v.q   = q;
        v.a   = a;
        return v;
    endfunction

    task automatic load_row(input vec_t v);
        for (int a = 0; a < 4; a++) tb_mem[{v.st, 2'(a)}] = v.row[a];
    endtask

    task automatic expect_scan(input vec_t v);
        exp_t e;
        for (int a = 0; a < 4; a++) addr_q.push_back({v.st, 2'(a)});
        e.q = v.q;
        e.a = v.a;
        exp_q.push_back(e);
    endtask

    task automatic wait_valid(input int req_cyc, input string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) fail_now({nm, " timeout waiting for o_valid"});
        else chk(nm, cyc, req_cyc);
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "_rd_en"}, {31'd0, o_rd_en}, 32'd0);
        chk({nm, "_rd_addr"}, {26'd0, o_rd_addr}, 32'd0);
        chk({nm, "_max_q"}, o_max_q, 32'd0);
        chk({nm, "_valid"}, {31'd0, o_valid}, 32'd0);
        chk({nm, "_busy"}, {31'd0, o_busy}, 32'd0);
`ifdef Q_MAX_ACTION_OUT_EN
        chk({nm, "_action"}, {30'd0, o_max_action}, 32'd0);
`endif
    endtask

    // Single scan: accept at edge 0, o_valid expected in cycle N+2 = 6
    task automatic run_scan(input vec_t v);
        int c1;
        load_row(v);
        expect_scan(v);
        @(negedge clk);
        i_valid      = 1'b1;
        i_next_state = v.st;
        @(negedge clk);
        i_valid      = 1'b0;
        i_next_state = ~v.st;
        c1 = cyc;
        chk("busy_cycle1", {31'd0, o_busy}, 32'd1);
        wait_valid(c1 + 5, "valid_cycle");
        @(negedge clk);
        chk("valid_drop", {31'd0, o_valid}, 32'd0);
        chk("hold_max_q", o_max_q, v.q);
        chk("busy_after", {31'd0, o_busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs [8];
        vec_t va, vb, vr, vf;
        int   c1;

        for (int i = 0; i < 64; i++) tb_mem[i] = 32'd0;

        vecs[0] = mk(4'd5,  32'h3F800000, 32'h40400000, 32'h3F000000, 32'h40000000, 32'h40400000, 2'd1);
        vecs[1] = mk(4'd6,  32'hBF800000, 32'hBF000000, 32'hC0000000, 32'hC0400000, 32'hBF000000, 2'd1);
        vecs[2] = mk(4'd7,  32'h80000000, 32'h00000000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 2'd2);
        vecs[3] = mk(4'd8,  32'h00000000, 32'h80000000, 32'hBF800000, 32'hBF800000, 32'h00000000, 2'd0);
        vecs[4] = mk(4'd10, 32'hBF800000, 32'h3F000000, 32'hC0000000, 32'h3E800000, 32'h3F000000, 2'd1);
        vecs[5] = mk(4'd11, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40800000, 2'd3);
        vecs[6] = mk(4'd12, 32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000, 2'd0);
        vecs[7] = mk(4'd13, 32'hC0400000, 32'hBF800000, 32'h80000000, 32'hC0000000, 32'h80000000, 2'd2);

        va = mk(4'd9,  32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40800000, 2'd3);
        vb = mk(4'd14, 32'hC0000000, 32'h3FC00000, 32'h3FC00000, 32'h3F000000, 32'h3FC00000, 2'd1);
        vr = mk(4'd15, 32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41000000, 2'd3);
        vf = mk(4'd15, 32'h3F000000, 32'h3E800000, 32'h3F400000, 32'h00000000, 32'h3F400000, 2'd2);

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int t = 0; t < 8; t++) run_scan(vecs[t]);

        // Requests during a scan and in DONE are dropped; cycle 7 restarts
        load_row(va);
        load_row(vb);
        expect_scan(va);
        @(negedge clk);
        i_valid      = 1'b1;
        i_next_state = va.st;
        @(negedge clk);
        i_valid = 1'b0;
        c1 = cyc;
        @(negedge clk);
        @(negedge clk);
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        i_valid = 1'b1;
        chk("ignore_valid_c6", {31'd0, o_valid}, 32'd1);
        chk("ignore_cycle_c6", cyc, c1 + 5);
        @(negedge clk);
        i_next_state = vb.st;
        expect_scan(vb);
        chk("restart_idle_c7", {31'd0, o_busy}, 32'd0);
        @(negedge clk);
        i_valid      = 1'b0;
        i_next_state = 4'd0;
        wait_valid(c1 + 12, "second_valid_c13");
        @(negedge clk);

        // Asynchronous reset in cycle 3 aborts the scan
        load_row(vr);
        expect_scan(vr);
        @(negedge clk);
        i_valid      = 1'b1;
        i_next_state = vr.st;
        @(negedge clk);
        i_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        addr_q.delete();
        exp_q.delete();
        repeat (3) @(negedge clk);
        check_all_zero("abort_hold");
        rst_n = 1'b1;
        @(negedge clk);
        run_scan(vf);

        repeat (4) @(negedge clk);
        chk("exp_q_empty", exp_q.size(), 32'd0);
        chk("addr_q_empty", addr_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
